// File: rtl/axi_ram_slave.sv
// rtl/axi_ram_slave.sv - AXI3-style INCR burst slave over a single 32-bit word RAM
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   ar*  / r*                        read address channel / read data channel
//   aw*  / w* / b*                   write address / write data / write response channels
// Read and write FSMs run independently on one array (one read port, one write port).

module axi_ram_slave #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    // read address channel
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic        arvalid,
    output logic        arready,
    // read data channel
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    // write address channel
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic        awvalid,
    output logic        awready,
    // write data channel
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // write response channel
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] R_IDLE  = 1'b0;
    localparam logic [0:0] R_BURST = 1'b1;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    logic [31:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    logic [0:0]            rstate;
    logic [ADDR_WIDTH-1:0] ridx;
    logic [3:0]            rlen;
    logic [3:0]            rcnt;
    logic [ADDR_WIDTH-1:0] ar_idx;
    logic [ADDR_WIDTH-1:0] ridx_next;

    assign arready   = (rstate == R_IDLE);
    assign rvalid    = (rstate == R_BURST);
    assign rresp     = 2'b00;
    assign ar_idx    = araddr[ADDR_WIDTH+1:2];
    assign ridx_next = ridx + ADDR_WIDTH'(1);

    // rdata is a registered copy of the word, loaded when a beat is set up.
    // A write landing on the same word in that cycle is not seen, so the
    // read returns the pre-write value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate <= R_IDLE;
            rid    <= 4'd0;
            rdata  <= 32'd0;
            rlast  <= 1'b0;
            ridx   <= '0;
            rlen   <= 4'd0;
            rcnt   <= 4'd0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (arvalid) begin
                        rid    <= arid;
                        ridx   <= ar_idx;
                        rlen   <= arlen;
                        rcnt   <= 4'd0;
                        rdata  <= mem[ar_idx];
                        rlast  <= (arlen == 4'd0);
                        rstate <= R_BURST;
                    end
                end
                default: begin
                    if (rready) begin
                        if (rlast) begin
                            rlast  <= 1'b0;
                            rstate <= R_IDLE;
                        end else begin
                            ridx  <= ridx_next;
                            rcnt  <= rcnt + 4'd1;
                            rdata <= mem[ridx_next];
                            rlast <= ((rcnt + 4'd1) == rlen);
                        end
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic [1:0]            wstate;
    logic [ADDR_WIDTH-1:0] widx;
    logic [3:0]            wlen;
    logic [3:0]            wcnt;
    logic                  werr;
    logic                  w_fire;
    logic                  w_final;

    assign awready = (wstate == W_IDLE);
    assign wready  = (wstate == W_DATA);
    assign bvalid  = (wstate == W_RESP);
    assign bresp   = (bvalid && werr) ? 2'b10 : 2'b00;
    assign w_fire  = wvalid && wready;
    assign w_final = (wcnt == wlen);

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate <= W_IDLE;
            bid    <= 4'd0;
            widx   <= '0;
            wlen   <= 4'd0;
            wcnt   <= 4'd0;
            werr   <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (awvalid) begin
                        bid    <= awid;
                        widx   <= awaddr[ADDR_WIDTH+1:2];
                        wlen   <= awlen;
                        wcnt   <= 4'd0;
                        werr   <= 1'b0;
                        wstate <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        widx <= widx + ADDR_WIDTH'(1);
                        wcnt <= wcnt + 4'd1;
                        // The beat count, not wlast, ends the burst; a
                        // disagreeing wlast only marks the response.
                        if (wlast != w_final) begin
                            werr <= 1'b1;
                        end
                        if (w_final) begin
                            wstate <= W_RESP;
                        end
                    end
                end
                default: begin
                    if (bready) begin
                        wstate <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // Memory is never reset; writes are suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && w_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// tb/tb_axi_ram_slave.sv - directed scoreboard bench for axi_ram_slave

module tb_axi_ram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    axi_ram_slave #(.ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] model [1024];
    logic [32:0] rq [$];      // {rlast, rdata}
    logic [5:0]  bq [$];      // {bresp, bid}

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic        wl [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        vectors++;
        errors++;
        $display("FAIL %s timeout waiting for DUT", tag);
    endtask

    task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                      input logic [1:0] eresp);
        int n;
        logic [9:0] idx;
        logic [5:0] e;
        bq.push_back({eresp, id});
        awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) timeout("aw_handshake");
        @(negedge clk);
        awvalid = 1'b0;
        idx = addr[11:2];
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = wl[i];
            n = 0;
            while (!wready && n < 20) begin @(negedge clk); n++; end
            if (n >= 20) timeout("w_beat");
            for (int b = 0; b < 4; b++)
                if (ws[i][b]) model[idx][8*b +: 8] = wd[i][8*b +: 8];
            idx = idx + 10'd1;
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) timeout("b_resp");
        e = bq.pop_front();
        chk("bid", {28'd0, bid}, {28'd0, e[3:0]});
        chk("bresp", {30'd0, bresp}, {30'd0, e[5:4]});
        @(negedge clk);
        chk("awready_after_b", {31'd0, awready}, 32'd1);
    endtask

    task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                      input bit stall);
        int n;
        logic [9:0] idx;
        logic [32:0] e;
        idx = addr[11:2];
        for (int i = 0; i <= int'(len); i++) begin
            rq.push_back({(i == int'(len)), model[idx]});
            idx = idx + 10'd1;
        end
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) timeout("ar_handshake");
        @(negedge clk);
        arvalid = 1'b0;
        chk("rvalid_one_cycle_after_ar", {31'd0, rvalid}, 32'd1);
        chk("rid", {28'd0, rid}, {28'd0, id});
        for (int i = 0; i <= int'(len); i++) begin
            if (stall) begin
                rready = 1'b0;
                e = rq[0];
                chk("rdata_stall", rdata, e[31:0]);
                chk("rlast_stall", {31'd0, rlast}, {31'd0, e[32]});
                @(negedge clk);
            end
            rready = 1'b1;
            n = 0;
            while (!rvalid && n < 20) begin @(negedge clk); n++; end
            if (n >= 20) timeout("r_beat");
            e = rq.pop_front();
            chk("rdata", rdata, e[31:0]);
            chk("rlast", {31'd0, rlast}, {31'd0, e[32]});
            chk("rresp", {30'd0, rresp}, 32'd0);
            @(negedge clk);
            rready = 1'b0;
        end
        chk("arready_after_r", {31'd0, arready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        arid = 0; araddr = 0; arlen = 0; arvalid = 0; rready = 0;
        awid = 0; awaddr = 0; awlen = 0; awvalid = 0;
        wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_arready", {31'd0, arready}, 32'd1);
        chk("rst_awready", {31'd0, awready}, 32'd1);
        chk("rst_wready", {31'd0, wready}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rlast", {31'd0, rlast}, 32'd0);
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rid", {28'd0, rid}, 32'd0);
        chk("rst_bid", {28'd0, bid}, 32'd0);
        chk("rst_bresp", {30'd0, bresp}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single beat write/read
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF; wl[0] = 1'b1;
        wr(4'd3, 32'h40, 4'd0, 2'b00);
        rd(4'd5, 32'h40, 4'd0, 1'b0);
        chk("single_const", model[16], 32'hDEADBEEF);

        // 8-beat write then stalled 8-beat read
        for (int i = 0; i < 8; i++) begin
            wd[i] = i; ws[i] = 4'hF; wl[i] = (i == 7);
        end
        wr(4'd7, 32'h100, 4'd7, 2'b00);
        rd(4'd9, 32'h100, 4'd7, 1'b1);

        // partial strobes
        wd[0] = 32'h11223344; ws[0] = 4'hF; wl[0] = 1'b1;
        wr(4'd1, 32'h8, 4'd0, 2'b00);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101; wl[0] = 1'b1;
        wr(4'd2, 32'h8, 4'd0, 2'b00);
        rq.push_back({1'b1, 32'h11BB33DD});
        arid = 4'd4; araddr = 32'h8; arlen = 4'd0; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        begin
            logic [32:0] e;
            e = rq.pop_front();
            chk("strobe_merge", rdata, e[31:0]);
        end
        @(negedge clk);
        rready = 1'b0;

        // zero strobe beat leaves memory alone
        wd[0] = 32'h0BADF00D; ws[0] = 4'b0000; wl[0] = 1'b1;
        wr(4'd6, 32'h40, 4'd0, 2'b00);
        rd(4'd6, 32'h40, 4'd0, 1'b0);

        // wrap at top of memory
        wd[0] = 32'hCAFE0001; wd[1] = 32'hCAFE0002;
        ws[0] = 4'hF; ws[1] = 4'hF; wl[0] = 1'b0; wl[1] = 1'b1;
        wr(4'd8, 32'hFFC, 4'd1, 2'b00);
        rd(4'd8, 32'hFFC, 4'd1, 1'b0);
        rd(4'd8, 32'h0, 4'd0, 1'b0);

        // early wlast: burst runs to awlen, response is SLVERR
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'h5000 + i; ws[i] = 4'hF; wl[i] = (i == 1);
        end
        wr(4'd10, 32'h200, 4'd3, 2'b10);
        rd(4'd11, 32'h200, 4'd3, 1'b0);

        // reset during beat 3 of 8
        arid = 4'd12; araddr = 32'h100; arlen = 4'd7; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        chk("rst_burst_beat0", rdata, model[64]);
        @(negedge clk);
        chk("rst_burst_beat1", rdata, model[65]);
        @(negedge clk);
        rready = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("midrst_arready", {31'd0, arready}, 32'd1);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_rid", {28'd0, rid}, 32'd0);
        rd(4'd13, 32'h100, 4'd7, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
